// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants and ID/EX payload type
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int FUNCCODE_W = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [XLEN-1:0]       A;
    logic [XLEN-1:0]       B;
    logic [XLEN-1:0]       pc;
    logic [FUNCCODE_W-1:0] FuncCode;
    logic [6:0]            Opcode;
    logic [4:0]            rd;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } id_ex_state_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side and execute-side handshakes of the ID/EX stage
interface id_ex_stage_if
  import rv32i_pkg::*;
  ();

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_A;
  logic [XLEN-1:0]       in_B;
  logic [XLEN-1:0]       in_pc;
  logic                  flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_A;
  logic [XLEN-1:0]       out_B;
  logic [FUNCCODE_W-1:0] out_FuncCode;
  logic [6:0]            out_Opcode;
  logic [4:0]            out_rd;
  logic [XLEN-1:0]       out_pc;

  // Decode/EX environment side
  modport master (
    output in_valid, in_instr, in_A, in_B, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_A, out_B, out_FuncCode, out_Opcode, out_rd, out_pc
  );

  // Pipeline stage side
  modport slave (
    input  in_valid, in_instr, in_A, in_B, in_pc, flush, out_ready,
    output in_ready, out_valid, out_A, out_B, out_FuncCode, out_Opcode, out_rd, out_pc
  );

endinterface

// File: rtl/id_ex_decode.sv
// rtl/id_ex_decode.sv - combinational instr to FuncCode/Opcode/rd extractor
module id_ex_decode
  import rv32i_pkg::*;
(
  input  logic [31:0]           instr,
  output logic [FUNCCODE_W-1:0] func_code,
  output logic [6:0]            opcode,
  output logic [4:0]            rd
);

  logic [2:0] funct3;
  logic       alt_bit;
  logic       unused_bits;

  assign unused_bits = ^{instr[31], instr[29:15]};

  // Bit 30 only selects SUB/SRA for register ops and SRAI for immediates; elsewhere it is immediate data
  always_comb begin
    opcode  = instr[6:0];
    rd      = instr[11:7];
    funct3  = instr[14:12];
    alt_bit = 1'b0;
    if (opcode == OPC_OP) begin
      alt_bit = instr[30];
    end else if ((opcode == OPC_OP_IMM) && (funct3 == 3'b101)) begin
      alt_bit = instr[30];
    end
    func_code = {alt_bit, funct3};
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - registered ID to EX stage with two-entry skid buffer and flush
module id_ex_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  id_ex_stage_if.slave bus
);

  id_ex_state_t   state_q, state_d;
  id_ex_payload_t main_q, skid_q, in_payload;
  logic           in_ready_q;
  logic           in_fire, out_fire, out_valid;
  logic           load_main_in, load_skid, move_skid;

  logic [FUNCCODE_W-1:0] dec_func_code;
  logic [6:0]            dec_opcode;
  logic [4:0]            dec_rd;

  id_ex_decode u_decode (
    .instr     (bus.in_instr),
    .func_code (dec_func_code),
    .opcode    (dec_opcode),
    .rd        (dec_rd)
  );

  assign in_payload = '{A: bus.in_A, B: bus.in_B, pc: bus.in_pc,
                        FuncCode: dec_func_code, Opcode: dec_opcode, rd: dec_rd};

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q & ~bus.flush;
  assign out_fire  = out_valid & bus.out_ready;

  // Next-state and load selection; flush overrides every transition
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            move_skid = 1'b1;
            state_d   = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register and registered in_ready, which mirrors "next state has room"
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Payload registers change only on a load and otherwise keep their last contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_payload;
      end else if (move_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_payload;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_A        = main_q.A;
  assign bus.out_B        = main_q.B;
  assign bus.out_pc       = main_q.pc;
  assign bus.out_FuncCode = main_q.FuncCode;
  assign bus.out_Opcode   = main_q.Opcode;
  assign bus.out_rd       = main_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_popped = 0;
  int cycle    = 0;

  id_ex_payload_t sb_q[$];
  id_ex_payload_t prev_out;
  bit             prev_stall = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic id_ex_payload_t ref_model(input logic [31:0] instr, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] pc);
    id_ex_payload_t p;
    logic [2:0] f3;
    f3 = instr[14:12];
    p.A = a;
    p.B = b;
    p.pc = pc;
    p.Opcode = instr[6:0];
    p.rd = instr[11:7];
    case (instr[6:0])
      7'b0110011: p.FuncCode = {instr[30], f3};
      7'b0010011: p.FuncCode = (f3 == 3'b101) ? {instr[30], f3} : {1'b0, f3};
      default:    p.FuncCode = {1'b0, f3};
    endcase
    return p;
  endfunction

  function automatic id_ex_payload_t cur_out();
    id_ex_payload_t p;
    p.A = bus.out_A;
    p.B = bus.out_B;
    p.pc = bus.out_pc;
    p.FuncCode = bus.out_FuncCode;
    p.Opcode = bus.out_Opcode;
    p.rd = bus.out_rd;
    return p;
  endfunction

  // Monitor: sample mid-cycle what will fire on the next rising edge
  always @(negedge clk) begin
    id_ex_payload_t cur, exp;
    if (!rst_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      cur = cur_out();
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_payload", cur, prev_out);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", sb_q.size(), 1);
        end else begin
          exp = sb_q.pop_front();
          n_popped++;
          check("sb_payload", cur, exp);
        end
      end
      if (bus.flush) begin
        sb_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(ref_model(bus.in_instr, bus.in_A, bus.in_B, bus.in_pc));
        n_pushed++;
      end
      prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
      prev_out = cur;
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_A = a;
    bus.in_B = b;
    bus.in_pc = pc;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", ok, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", sb_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0: begin
        w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        w[6:0] = 7'b0110011;
      end
      1: w[6:0] = 7'b0010011;
      default: w[6:0] = 7'b0000011;
    endcase
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, p0, q0;
    bit done;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0020F1B3;
    bus.in_A = 32'h1;
    bus.in_B = 32'h2;
    bus.in_pc = 32'h3;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_payload", cur_out(), '0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_in_ready", bus.in_ready, 1'b1);
    check("rst_release_out_valid", bus.out_valid, 1'b0);

    // Basic decode and FuncCode gating
    bus.out_ready = 1'b1;
    send(32'h0020F1B3, 32'h0F, 32'h55, 32'h100);
    check("and_valid", bus.out_valid, 1'b1);
    check("and_funccode", bus.out_FuncCode, 4'b0111);
    check("and_opcode", bus.out_Opcode, 7'b0110011);
    check("and_rd", bus.out_rd, 5'd3);
    check("and_A", bus.out_A, 32'h0F);
    check("and_B", bus.out_B, 32'h55);
    send(32'h402081B3, 32'h7, 32'h2, 32'h104);
    check("sub_funccode", bus.out_FuncCode, 4'b1000);
    send(32'h4010D293, 32'h80000000, 32'h401, 32'h108);
    check("srai_funccode", bus.out_FuncCode, 4'b1101);
    check("srai_rd", bus.out_rd, 5'd5);
    send(32'hFFF00093, 32'h0, 32'hFFFFFFFF, 32'h10C);
    check("addi_funccode", bus.out_FuncCode, 4'b0000);
    wait_drain();

    // Back-to-back with out_ready high: one entry per cycle
    c0 = cycle;
    for (int i = 0; i < 8; i++) send(rand_instr(), $urandom, $urandom, 32'h200 + 4 * i);
    check("tput_cycles", cycle - c0, 8);
    wait_drain();

    // Back-pressure: out_ready low for three cycles after the first acceptance
    bus.out_ready = 1'b0;
    send(32'h00108093, 32'hA, 32'h1, 32'h0);
    check("bp_in_ready_one", bus.in_ready, 1'b1);
    fork
      begin
        send(32'h402081B3, 32'hB, 32'h2, 32'h4);
        check("bp_in_ready_two", bus.in_ready, 1'b0);
        send(32'h0020F1B3, 32'hC, 32'h3, 32'h8);
        send(32'h4010D293, 32'hD, 32'h4, 32'hC);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush while holding two entries, with a third offered
    bus.out_ready = 1'b0;
    send(32'h00108093, 32'h1, 32'h1, 32'h10);
    send(32'h00108093, 32'h2, 32'h2, 32'h14);
    check("flush_pre_in_ready", bus.in_ready, 1'b0);
    p0 = n_popped;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00108093;
    bus.in_pc = 32'h18;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_delivery", n_popped - p0, 0);

    // Reset while an entry is presented
    bus.out_ready = 1'b0;
    send(32'h0020F1B3, 32'h5, 32'h6, 32'h40);
    check("mid_rst_pre_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_payload", cur_out(), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_release_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_release_out_valid", bus.out_valid, 1'b0);

    // Random stream with random out_ready
    p0 = n_popped;
    q0 = n_pushed;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) send(rand_instr(), $urandom, $urandom, 32'h1000 + 4 * i);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 1) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    check("rand_accepted", n_pushed - q0, 100);
    check("rand_delivered", n_popped - p0, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
